addsub_arbiter: RTL

Shares a single `addsub_8bit` add/subtract unit between two requesters. Each requester presents operands and an operation; a round-robin (or fixed-priority) arbiter grants one, latches its operands, drives the shared unit for one cycle, registers the result and flags, and returns a one-cycle acknowledge. The block sits between the requesting control logic and the arithmetic datapath; it is the only driver of the shared unit's inputs.

---
 rtl/addsub_arbiter_if.sv | 28 ++
 rtl/addsub_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/addsub_arbiter_if.sv
// rtl/addsub_arbiter_if.sv - requester-side bundle for the shared add/subtract arbiter
interface addsub_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       op0;
    logic       op1;
    logic       ack0;
    logic       ack1;
    logic [1:0] gnt;
    logic       busy;
    logic [7:0] result;
    logic       cout;
    logic       ov_flag;

    modport master (
        output req0, req1, a0, b0, a1, b1, op0, op1,
        input  ack0, ack1, gnt, busy, result, cout, ov_flag
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, op0, op1,
        output ack0, ack1, gnt, busy, result, cout, ov_flag
    );
endinterface

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester arbiter sharing one 8-bit add/subtract unit
module addsub_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    output logic [7:0] sum,
    output logic       cout,
    output logic       ov
);
    logic [7:0] b_eff;
    logic [8:0] full;

    always_comb begin
        b_eff = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, b_eff} + {8'd0, sub};
        sum   = full[7:0];
        cout  = full[8];
        // overflow: both addend signs agree but the sum sign does not
        ov    = (a[7] == b_eff[7]) && (full[7] != a[7]);
    end
endmodule

module addsub_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    addsub_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state, state_next;
    logic       rr, rr_next;
    logic       sel, sel_next;
    logic       win;
    logic       latch;
    logic       load;
    logic [1:0] gnt_q, gnt_next;
    logic [1:0] ack_q, ack_next;
    logic       busy_q, busy_next;

    logic [7:0] a_q, b_q;
    logic       op_q;
    logic [7:0] sum;
    logic       cout_u, ov_u;
    logic [7:0] result_q;
    logic       cout_q, ov_q;

    addsub_8bit u_addsub (
        .a    (a_q),
        .b    (b_q),
        .sub  (op_q),
        .sum  (sum),
        .cout (cout_u),
        .ov   (ov_u)
    );

    always_comb begin
        state_next = state;
        rr_next    = rr;
        sel_next   = sel;
        gnt_next   = gnt_q;
        busy_next  = busy_q;
        ack_next   = 2'b00;
        win        = 1'b0;
        latch      = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    if (bus.req0 && bus.req1)
                        win = FIXED_PRIO ? 1'b0 : rr;
                    else
                        win = bus.req1;
                    latch      = 1'b1;
                    sel_next   = win;
                    gnt_next   = win ? 2'b10 : 2'b01;
                    busy_next  = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                load       = 1'b1;
                ack_next   = sel ? 2'b10 : 2'b01;
                state_next = DONE;
            end
            DONE: begin
                if (!FIXED_PRIO)
                    rr_next = ~sel;
                gnt_next   = 2'b00;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr       <= 1'b0;
            sel      <= 1'b0;
            gnt_q    <= 2'b00;
            busy_q   <= 1'b0;
            ack_q    <= 2'b00;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            op_q     <= 1'b0;
            result_q <= 8'd0;
            cout_q   <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state  <= state_next;
            rr     <= rr_next;
            sel    <= sel_next;
            gnt_q  <= gnt_next;
            busy_q <= busy_next;
            ack_q  <= ack_next;
            if (latch) begin
                a_q  <= win ? bus.a1  : bus.a0;
                b_q  <= win ? bus.b1  : bus.b0;
                op_q <= win ? bus.op1 : bus.op0;
            end
            if (load) begin
                result_q <= sum;
                cout_q   <= cout_u;
                ov_q     <= ov_u;
            end
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.ack0    = ack_q[0];
    assign bus.ack1    = ack_q[1];
    assign bus.result  = result_q;
    assign bus.cout    = cout_q;
    assign bus.ov_flag = ov_q;
endmodule
